// File: rtl/alu_exec_pkg.sv
// Shared types and sizes for the ALU sequencing/writeback stage.
// Optional feature macro used by this block: ALU_EXEC_STICKY_OVF_EN.
package alu_exec_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned REG_N  = 4;
    localparam int unsigned ADDR_W = 2;

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_SHL   = 3'd1,
        OP_SHR   = 3'd2,
        OP_AND   = 3'd3,
        OP_OR    = 3'd4,
        OP_COMP  = 3'd5,
        OP_LOADI = 3'd6,
        OP_NOP   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;

endpackage

// File: rtl/alu_exec_regfile.sv
// 4x8 register file: two read ports that load into output registers on
// rd_ld, one write port, and an asynchronous debug read port.
module alu_exec_regfile
    import alu_exec_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_ld,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] mem [REG_N];

    // Register storage: cleared on reset, single write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < REG_N; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read ports capture the addressed registers when an instruction is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data1 <= '0;
            rd_data2 <= '0;
        end else if (rd_ld) begin
            rd_data1 <= mem[rd_addr1];
            rd_data2 <= mem[rd_addr2];
        end
    end

    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Sequencing and writeback stage around a combinational 8-bit ALU.
// IDLE accepts an instruction and loads operands, EXEC lets the ALU settle,
// WB selects the result, writes it back and updates the flags.
// Optional feature macro: ALU_EXEC_STICKY_OVF_EN (sticky overflow flag,
// cleared by ovf_clr; otherwise ovf_clr is ignored).
module alu_exec_ctrl
    import alu_exec_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [2:0]  instr_op,
    input  logic [1:0]  instr_rd,
    input  logic [1:0]  instr_rs,
    input  logic [1:0]  instr_rt,
    input  logic [7:0]  instr_imm,
    output logic [7:0]  alu_in1,
    output logic [7:0]  alu_in2,
    input  logic [8:0]  alu_add,
    input  logic [7:0]  alu_shl,
    input  logic [7:0]  alu_shr,
    input  logic [7:0]  alu_and,
    input  logic [7:0]  alu_or,
    input  logic [7:0]  alu_comp,
    input  logic        alu_ov1,
    input  logic        alu_ov2,
    output logic        done,
    output logic [7:0]  result,
    output logic        flag_c,
    output logic        flag_z,
    output logic        flag_v,
    input  logic [1:0]  dbg_addr,
    output logic [7:0]  dbg_data,
    input  logic        ovf_clr
);

    state_e            state_q, state_d;
    op_e               op_q;
    logic [ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0] imm_q;
    logic              accept;
    logic              wb;
    logic              wb_write;
    logic [DATA_W-1:0] sel_data;
    logic              sel_c;
    logic              sel_v;

    assign accept   = instr_valid && instr_ready;
    assign wb       = (state_q == ST_WB);
    assign wb_write = wb && (op_q != OP_NOP);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake: only IDLE accepts, then a fixed EXEC/WB walk.
    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) state_d = ST_EXEC;
            end
            ST_EXEC: state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Latch the instruction fields that are needed after the accept cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= OP_NOP;
            rd_q  <= '0;
            imm_q <= '0;
        end else if (accept) begin
            op_q  <= op_e'(instr_op);
            rd_q  <= instr_rd;
            imm_q <= instr_imm;
        end
    end

    // Pick the opcode's result and its carry/overflow contribution.
    always_comb begin
        sel_data = '0;
        sel_c    = 1'b0;
        sel_v    = 1'b0;
        case (op_q)
            OP_ADD: begin
                sel_data = alu_add[7:0];
                sel_c    = alu_add[8];
                sel_v    = alu_ov1;
            end
            OP_SHL: begin
                sel_data = alu_shl;
                sel_c    = alu_ov2;
            end
            OP_SHR:   sel_data = alu_shr;
            OP_AND:   sel_data = alu_and;
            OP_OR:    sel_data = alu_or;
            OP_COMP:  sel_data = alu_comp;
            OP_LOADI: sel_data = imm_q;
            default:  sel_data = '0;
        endcase
    end

    // Retire: done pulse, held result and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done   <= 1'b0;
            result <= '0;
            flag_c <= 1'b0;
            flag_z <= 1'b0;
            flag_v <= 1'b0;
        end else begin
            done <= wb;
            if (wb_write) begin
                result <= sel_data;
                flag_z <= (sel_data == '0);
                flag_c <= sel_c;
            end
`ifdef ALU_EXEC_STICKY_OVF_EN
            // Setting ADD takes priority over a simultaneous clear.
            if (wb_write && sel_v) begin
                flag_v <= 1'b1;
            end else if (ovf_clr) begin
                flag_v <= 1'b0;
            end
`else
            if (wb_write) begin
                flag_v <= sel_v;
            end
`endif
        end
    end

`ifndef ALU_EXEC_STICKY_OVF_EN
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
`endif

    alu_exec_regfile u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_ld    (accept),
        .rd_addr1 (instr_rs),
        .rd_addr2 (instr_rt),
        .rd_data1 (alu_in1),
        .rd_data2 (alu_in2),
        .wr_en    (wb_write),
        .wr_addr  (rd_q),
        .wr_data  (sel_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Testbench for alu_exec_ctrl: directed steps plus random instructions,
// checked against an instruction-level reference model.
// Honours ALU_EXEC_STICKY_OVF_EN for the expected overflow flag.
module tb_alu_exec_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] instr_op;
    logic [1:0] instr_rd, instr_rs, instr_rt;
    logic [7:0] instr_imm;
    logic [7:0] alu_in1, alu_in2;
    logic [8:0] alu_add;
    logic [7:0] alu_shl, alu_shr, alu_and, alu_or, alu_comp;
    logic       alu_ov1, alu_ov2;
    logic       done;
    logic [7:0] result;
    logic       flag_c, flag_z, flag_v;
    logic [1:0] dbg_addr;
    logic [7:0] dbg_data;
    logic       ovf_clr;

    int vectors     = 0;
    int miscompares = 0;

    // Reference architectural state.
    logic [7:0] m_reg [4];
    logic [7:0] m_res;
    logic       m_z, m_c, m_v;

    always #5 clk = ~clk;

    // Combinational ALU stand-in fed by the DUT's operand buses.
    assign alu_add  = {1'b0, alu_in1} + {1'b0, alu_in2};
    assign alu_shl  = {alu_in2[6:0], 1'b0};
    assign alu_ov2  = alu_in2[7];
    assign alu_shr  = {1'b0, alu_in2[7:1]};
    assign alu_and  = alu_in1 & alu_in2;
    assign alu_or   = alu_in1 | alu_in2;
    assign alu_comp = ~alu_in1;
    assign alu_ov1  = (alu_in1[7] == alu_in2[7]) && (alu_add[7] != alu_in1[7]);

    alu_exec_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_rd    (instr_rd),
        .instr_rs    (instr_rs),
        .instr_rt    (instr_rt),
        .instr_imm   (instr_imm),
        .alu_in1     (alu_in1),
        .alu_in2     (alu_in2),
        .alu_add     (alu_add),
        .alu_shl     (alu_shl),
        .alu_shr     (alu_shr),
        .alu_and     (alu_and),
        .alu_or      (alu_or),
        .alu_comp    (alu_comp),
        .alu_ov1     (alu_ov1),
        .alu_ov2     (alu_ov2),
        .done        (done),
        .result      (result),
        .flag_c      (flag_c),
        .flag_z      (flag_z),
        .flag_v      (flag_v),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data),
        .ovf_clr     (ovf_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
        m_res = 8'h00;
        m_z = 1'b0; m_c = 1'b0; m_v = 1'b0;
    endtask

    // Architectural effect of one instruction, from plain arithmetic.
    task automatic model_apply(input logic [2:0] op, input logic [1:0] rd, rs, rt,
                               input logic [7:0] imm);
        int a, b, s, sa, sb;
        logic [7:0] sel;
        bit c, v;
        a = m_reg[rs];
        b = m_reg[rt];
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        c = 1'b0; v = 1'b0; sel = 8'h00;
        case (op)
            3'd0: begin s = a + b; sel = 8'(s); c = (s > 255); v = (sa + sb > 127) || (sa + sb < -128); end
            3'd1: begin s = b * 2; sel = 8'(s); c = (b >= 128); end
            3'd2: sel = 8'(b / 2);
            3'd3: sel = 8'(a & b);
            3'd4: sel = 8'(a | b);
            3'd5: sel = 8'(255 - a);
            3'd6: sel = imm;
            default: sel = 8'h00;
        endcase
        if (op != 3'd7) begin
            m_reg[rd] = sel;
            m_res = sel;
            m_z = (sel == 8'h00);
            m_c = c;
`ifndef ALU_EXEC_STICKY_OVF_EN
            m_v = v;
`endif
        end
`ifdef ALU_EXEC_STICKY_OVF_EN
        if (op == 3'd0 && v) m_v = 1'b1;
        else if (ovf_clr) m_v = 1'b0;
`endif
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_result"}, result, m_res);
        chk({tag, "_flag_z"}, flag_z, m_z);
        chk({tag, "_flag_c"}, flag_c, m_c);
        chk({tag, "_flag_v"}, flag_v, m_v);
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            chk({tag, "_dbg"}, dbg_data, m_reg[i]);
        end
    endtask

    // Issue one instruction and check operands, latency and retire state.
    task automatic issue(input logic [2:0] op, input logic [1:0] rd, rs, rt,
                         input logic [7:0] imm);
        logic [7:0] a, b;
        @(negedge clk);
        chk("ready_idle", instr_ready, 1);
        instr_valid = 1'b1;
        instr_op = op; instr_rd = rd; instr_rs = rs; instr_rt = rt; instr_imm = imm;
        dbg_addr = rd;
        a = m_reg[rs];
        b = m_reg[rt];
        @(posedge clk); #1;
        instr_valid = 1'b0;
        chk("alu_in1", alu_in1, a);
        chk("alu_in2", alu_in2, b);
        chk("ready_busy", instr_ready, 0);
        chk("done_accept", done, 0);
        model_apply(op, rd, rs, rt, imm);
        @(posedge clk); #1;
        chk("done_exec", done, 0);
        @(posedge clk); #1;
        chk("done_wb", done, 1);
        chk("ready_after", instr_ready, 1);
        chk("dbg_rd", dbg_data, m_reg[rd]);
        check_state("retire");
    endtask

    task automatic clear_ovf();
        @(negedge clk);
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
`ifdef ALU_EXEC_STICKY_OVF_EN
        m_v = 1'b0;
`endif
        chk("ovf_clr", flag_v, m_v);
    endtask

    initial begin
        logic [5:0] acc, dn;
        int n_acc;
        bit rdy;

        rst_n = 1'b0; instr_valid = 1'b0; instr_op = 3'd7;
        instr_rd = 2'd0; instr_rs = 2'd0; instr_rt = 2'd0; instr_imm = 8'h00;
        dbg_addr = 2'd0; ovf_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Reset state.
        chk("rst_ready", instr_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_in1", alu_in1, 0);
        chk("rst_in2", alu_in2, 0);
        check_state("rst");
        check_regs("rst");

        // 0x7F + 0x01: signed overflow, no carry.
        issue(3'd6, 2'd1, 2'd0, 2'd0, 8'h7F);
        issue(3'd6, 2'd2, 2'd0, 2'd0, 8'h01);
        issue(3'd0, 2'd3, 2'd1, 2'd2, 8'h00);
        chk("add_7f_res", result, 8'h80);
        chk("add_7f_v", flag_v, 1);

        // 0xFF + 0x01: zero with carry.
        issue(3'd6, 2'd1, 2'd0, 2'd0, 8'hFF);
        issue(3'd6, 2'd2, 2'd0, 2'd0, 8'h01);
        issue(3'd0, 2'd0, 2'd1, 2'd2, 8'h00);
        chk("add_ff_z", flag_z, 1);
        chk("add_ff_c", flag_c, 1);

        // NOP keeps result and flags.
        issue(3'd7, 2'd2, 2'd1, 2'd2, 8'h55);

        // Shifts use rt only.
        issue(3'd6, 2'd2, 2'd0, 2'd0, 8'h81);
        issue(3'd1, 2'd1, 2'd3, 2'd2, 8'h00);
        chk("shl_res", result, 8'h02);
        chk("shl_c", flag_c, 1);
        issue(3'd2, 2'd1, 2'd3, 2'd2, 8'h00);
        chk("shr_res", result, 8'h40);
        chk("shr_c", flag_c, 0);

        // Same register as source and destination.
        issue(3'd0, 2'd1, 2'd1, 2'd1, 8'h00);

        // instr_valid held for 6 cycles with two payloads.
        @(negedge clk);
        instr_valid = 1'b1;
        instr_op = 3'd6; instr_rd = 2'd0; instr_rs = 2'd3; instr_rt = 2'd3; instr_imm = 8'h5A;
        acc = '0; dn = '0; n_acc = 0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            rdy = instr_ready;
            @(posedge clk); #1;
            if (rdy) begin
                acc[k] = 1'b1;
                n_acc++;
                if (n_acc == 1) begin
                    instr_op = 3'd4; instr_rd = 2'd1; instr_rs = 2'd0; instr_rt = 2'd0; instr_imm = 8'h00;
                end
            end
            dn[k] = done;
        end
        instr_valid = 1'b0;
        model_apply(3'd6, 2'd0, 2'd3, 2'd3, 8'h5A);
        model_apply(3'd4, 2'd1, 2'd0, 2'd0, 8'h00);
        chk("held_accepts", acc, 6'b001001);
        chk("held_done", dn, 6'b100100);
        check_state("held");
        check_regs("held");

        // Overflow flag behaviour across ADD, AND and ovf_clr.
        issue(3'd6, 2'd1, 2'd0, 2'd0, 8'h40);
        issue(3'd0, 2'd3, 2'd1, 2'd1, 8'h00);
        issue(3'd3, 2'd0, 2'd1, 2'd1, 8'h00);
        clear_ovf();
        ovf_clr = 1'b1;
        issue(3'd0, 2'd3, 2'd1, 2'd1, 8'h00);
        ovf_clr = 1'b0;
        chk("set_wins_v", flag_v, 1);

        // Random instructions.
        for (int n = 0; n < 60; n++) begin
            issue(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 7) == 0) clear_ovf();
        end
        check_regs("rand");

        // Reset during EXEC aborts the ADD.
        issue(3'd6, 2'd1, 2'd0, 2'd0, 8'h33);
        @(negedge clk);
        instr_valid = 1'b1;
        instr_op = 3'd0; instr_rd = 2'd3; instr_rs = 2'd1; instr_rt = 2'd1; instr_imm = 8'h00;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        chk("abort_busy", instr_ready, 0);
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_ready", instr_ready, 1);
        dn = '0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            dn[k] = done;
        end
        chk("abort_no_done", dn, 6'b000000);
        check_state("abort");
        check_regs("abort");

        // Normal operation after the abort.
        issue(3'd6, 2'd2, 2'd0, 2'd0, 8'hC3);
        issue(3'd5, 2'd3, 2'd2, 2'd0, 8'h00);
        check_regs("post");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
